rr_burst_arbiter: RTL

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

---
 rtl/arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_burst_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and default sizing for the round-robin burst arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    localparam int ARB_N_REQ  = 4;
    localparam int ARB_DATA_W = 16;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set bit of mask_i found by searching upward from ptr_i+1 with wrap-around.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ
) (
    input  logic [N_REQ-1:0]         mask_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic                     found_o,
    output logic [$clog2(N_REQ)-1:0] index_o
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] j;

    // Walk the N_REQ positions after ptr_i; the first hit is kept, later hits are ignored.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        j       = ptr_i;
        for (int k = 0; k < N_REQ; k++) begin
            j = (j == IW'(N_REQ - 1)) ? '0 : j + 1'b1;
            if (mask_i[j] && !found_o) begin
                found_o = 1'b1;
                index_o = j;
            end
        end
    end

endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: round-robin arbiter that locks onto a requester for a whole burst
// and forwards beats through a single registered output stage.
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ  = ARB_N_REQ,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [$clog2(N_REQ)-1:0] out_id,
    input  logic                     out_ready
);

    localparam int IW = $clog2(N_REQ);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     lock_q, lock_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IW-1:0]     out_id_q, out_id_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              reg_free;
    logic              grant_ok;
    logic [IW-1:0]     grant_idx;
    logic              accept;
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .mask_i (req_valid),
        .ptr_i  (ptr_q),
        .found_o(pick_found),
        .index_o(pick_idx)
    );

    // While locked the search result is ignored: only the lock holder may move a beat.
    assign reg_free  = !out_valid_q || out_ready;
    assign grant_idx = (state_q == LOCKED) ? lock_q : pick_idx;
    assign grant_ok  = (state_q == LOCKED) ? req_valid[lock_q] : pick_found;
    assign accept    = rst_n && reg_free && grant_ok;
    assign req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        out_valid_d = reg_free ? accept : out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_id_d    = out_id_q;
        if (accept) begin
            out_data_d = data_arr[grant_idx];
            out_last_d = req_last[grant_idx];
            out_id_d   = grant_idx;
            ptr_d      = grant_idx;
            lock_d     = grant_idx;
            state_d    = req_last[grant_idx] ? IDLE : LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(N_REQ - 1);
            lock_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_id) && $stable(out_last)));

endmodule
